// File: rtl/frac_clken_gen_if.sv
// Register bus and clock-enable outputs of the fractional clock-enable generator.
// master drives writes/sync (CPU side), slave is the NCO bank.
interface frac_clken_gen_if #(
    parameter int NUM_CH    = 2,
    parameter int ACC_WIDTH = 24
);
    logic                 wr_en;
    logic [2:0]           wr_ch;
    logic                 wr_sel;
    logic [ACC_WIDTH-1:0] wr_data;
    logic [ACC_WIDTH-1:0] rd_data;
    logic [NUM_CH-1:0]    rd_en_mask;
    logic                 sync;
    logic [NUM_CH-1:0]    clken;
    logic [NUM_CH-1:0]    clk_sq;
    logic                 ready;

    modport master (
        output wr_en, wr_ch, wr_sel, wr_data, sync,
        input  rd_data, rd_en_mask, clken, clk_sq, ready
    );

    modport slave (
        input  wr_en, wr_ch, wr_sel, wr_data, sync,
        output rd_data, rd_en_mask, clken, clk_sq, ready
    );
endinterface

// File: rtl/frac_clken_gen.sv
// Multi-channel NCO bank: each channel adds its increment to a phase
// accumulator every clk; carry-out is a one-cycle enable pulse and the
// accumulator MSB is a ~50% square wave. Includes a settle counter that
// raises ready a fixed number of cycles after reset, like a PLL lock.
module frac_clken_gen #(
    parameter int                NUM_CH           = 2,
    parameter int                ACC_WIDTH        = 24,
    parameter longint unsigned   INCLOCK_FREQ     = 64'd22579200,
    parameter longint unsigned   DEFAULT_OUT_FREQ = 64'd44100,
    parameter logic [NUM_CH-1:0] ENABLE_MASK      = {NUM_CH{1'b1}},
    parameter int                SETTLE_CYCLES    = 1024
) (
    input  logic             clk,
    input  logic             nrst,
    frac_clken_gen_if.slave  bus
);
    // Largest legal increment: clk/2 output, still a valid square wave.
    localparam longint unsigned HALF    = 64'd1 << (ACC_WIDTH - 1);
    localparam longint unsigned RAW_INC =
        (DEFAULT_OUT_FREQ * (64'd1 << ACC_WIDTH) + INCLOCK_FREQ / 2) / INCLOCK_FREQ;
    localparam logic [ACC_WIDTH-1:0] HALF_W      = ACC_WIDTH'(HALF);
    localparam logic [ACC_WIDTH-1:0] DEFAULT_INC =
        (RAW_INC > HALF) ? HALF_W : ACC_WIDTH'(RAW_INC);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_W = SW'(SETTLE_CYCLES);

    logic [NUM_CH-1:0][ACC_WIDTH-1:0] inc_q, inc_d;
    logic [NUM_CH-1:0]                en_q, en_d;
    logic [ACC_WIDTH-1:0]             rd_q, rd_d;
    logic [SW-1:0]                    settle_q, settle_d;
    logic                             ready_q, ready_d;
    logic [ACC_WIDTH-1:0]             wr_sat;
    logic [NUM_CH-1:0]                clken_w, sq_w;

    assign wr_sat = (bus.wr_data > HALF_W) ? HALF_W : bus.wr_data;

    // Register-bus decode: writes to channels >= NUM_CH match no lane and
    // are dropped; read-back of such a channel yields zero.
    always_comb begin
        inc_d = inc_q;
        en_d  = en_q;
        rd_d  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.wr_ch == 3'(c)) begin
                rd_d = inc_q[c];
                if (bus.wr_en) begin
                    if (bus.wr_sel) en_d[c]  = bus.wr_data[0];
                    else            inc_d[c] = wr_sat;
                end
            end
        end
    end

    // Settle counter stops once ready is reached; ready is sticky until reset.
    always_comb begin
        settle_d = settle_q;
        ready_d  = ready_q;
        if (!ready_q) begin
            settle_d = settle_q + SW'(1);
            if (settle_q + SW'(1) == SETTLE_W) ready_d = 1'b1;
        end
    end

    // Control/status registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            inc_q    <= {NUM_CH{DEFAULT_INC}};
            en_q     <= ENABLE_MASK;
            rd_q     <= '0;
            settle_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            inc_q    <= inc_d;
            en_q     <= en_d;
            rd_q     <= rd_d;
            settle_q <= settle_d;
            ready_q  <= ready_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        logic [ACC_WIDTH-1:0] acc_q, acc_d;
        logic                 clken_q, clken_d;
        logic                 sq_q, sq_d;
        logic [ACC_WIDTH:0]   sum;

        assign sum = {1'b0, acc_q} + {1'b0, inc_q[g]};

        // Phase step: sync overrides everything, a disabled lane freezes its
        // phase and square wave so re-enable resumes where it left off.
        always_comb begin
            acc_d   = acc_q;
            clken_d = 1'b0;
            sq_d    = sq_q;
            if (bus.sync) begin
                acc_d = '0;
                sq_d  = 1'b0;
            end else if (en_q[g]) begin
                acc_d   = sum[ACC_WIDTH-1:0];
                clken_d = sum[ACC_WIDTH];
                sq_d    = sum[ACC_WIDTH-1];
            end
        end

        // Lane accumulator and registered outputs.
        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                acc_q   <= '0;
                clken_q <= 1'b0;
                sq_q    <= 1'b0;
            end else begin
                acc_q   <= acc_d;
                clken_q <= clken_d;
                sq_q    <= sq_d;
            end
        end

        assign clken_w[g] = clken_q;
        assign sq_w[g]    = sq_q;
    end

    assign bus.clken      = clken_w;
    assign bus.clk_sq     = sq_w;
    assign bus.rd_data    = rd_q;
    assign bus.rd_en_mask = en_q;
    assign bus.ready      = ready_q;
endmodule

// File: tb/tb_frac_clken_gen.sv
// Randomized scoreboard bench: the driver pushes the expected post-edge
// outputs computed by a phase/frequency model; a monitor pops and compares
// one entry after each rising edge.
module tb_frac_clken_gen;
    localparam int     NCH  = 2;
    localparam int     W    = 24;
    localparam longint MOD  = 64'd1 << W;
    localparam longint HALF = MOD / 2;
    localparam longint DEF_INC = 32768;   // 44100 Hz from 22.5792 MHz, 24-bit
    localparam int     SETTLE  = 1024;

    logic clk  = 1'b0;
    logic nrst = 1'b0;

    frac_clken_gen_if #(.NUM_CH(NCH), .ACC_WIDTH(W)) bus ();
    frac_clken_gen #(.NUM_CH(NCH), .ACC_WIDTH(W)) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0] ck;
        logic [NCH-1:0] sq;
        logic [NCH-1:0] en;
        logic [W-1:0]   rd;
        logic           rdy;
    } exp_t;

    exp_t   q[$];
    exp_t   me;
    longint ph[NCH];
    longint inc[NCH];
    bit     en[NCH];
    bit     ck[NCH];
    bit     sq[NCH];
    longint rd;
    int     since;
    int     rd_ch;
    int     checks;
    int     failures;
    int     shown;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            ph[c] = 0; inc[c] = DEF_INC; en[c] = 1'b1; ck[c] = 1'b0; sq[c] = 1'b0;
        end
        rd = 0;
        since = 0;
    endfunction

    // One clock of the reference: phase advances by the frequency word,
    // wrapping produces a pulse, the upper half of the cycle is clk_sq high.
    function automatic void model_step(bit we, int ch, bit sel, longint d, bit sy);
        exp_t   e;
        longint old_inc[NCH];
        if (!nrst) begin
            model_reset();
        end else begin
            for (int c = 0; c < NCH; c++) old_inc[c] = inc[c];
            for (int c = 0; c < NCH; c++) begin
                if (sy) begin
                    ph[c] = 0; ck[c] = 1'b0; sq[c] = 1'b0;
                end else if (en[c]) begin
                    ck[c] = (ph[c] + old_inc[c]) >= MOD;
                    ph[c] = (ph[c] + old_inc[c]) % MOD;
                    sq[c] = ph[c] >= HALF;
                end else begin
                    ck[c] = 1'b0;
                end
            end
            rd = (ch < NCH) ? old_inc[ch] : 0;
            if (we && ch < NCH) begin
                if (sel) en[ch] = (d % 2) == 1;
                else     inc[ch] = (d > HALF) ? HALF : d;
            end
            if (since < SETTLE) since++;
        end
        for (int c = 0; c < NCH; c++) begin
            e.ck[c] = ck[c]; e.sq[c] = sq[c]; e.en[c] = en[c];
        end
        e.rd  = W'(rd);
        e.rdy = since >= SETTLE;
        q.push_back(e);
    endfunction

    task automatic cyc(input bit we, input int ch, input bit sel,
                       input logic [W-1:0] d, input bit sy);
        @(negedge clk);
        bus.wr_en   = we;
        bus.wr_ch   = 3'(ch);
        bus.wr_sel  = sel;
        bus.wr_data = d;
        bus.sync    = sy;
        model_step(we, ch, sel, longint'(d), sy);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, rd_ch, 1'b0, '0, 1'b0);
    endtask

    task automatic wr(input int ch, input bit sel, input logic [W-1:0] d);
        rd_ch = ch;
        cyc(1'b1, ch, sel, d, 1'b0);
    endtask

    task automatic release_rst();
        @(negedge clk);
        nrst = 1'b1;
        bus.wr_en = 1'b0; bus.wr_ch = 3'(rd_ch); bus.wr_sel = 1'b0;
        bus.wr_data = '0; bus.sync = 1'b0;
        model_step(1'b0, rd_ch, 1'b0, 0, 1'b0);
    endtask

    // Async reset mid-cycle: outputs must clear without waiting for an edge.
    task automatic async_rst();
        @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        checks++;
        if (bus.clken !== '0 || bus.clk_sq !== '0 || bus.ready !== 1'b0 || bus.rd_data !== '0) begin
            failures++;
            $display("FAIL async_reset clken=%b clk_sq=%b ready=%b rd=%h (want all zero)",
                     bus.clken, bus.clk_sq, bus.ready, bus.rd_data);
        end
        bus.wr_en = 1'b0; bus.sync = 1'b0;
        model_step(1'b0, rd_ch, 1'b0, 0, 1'b0);
        repeat (3) cyc(1'b0, rd_ch, 1'b0, '0, 1'b0);
    endtask

    // Monitor: outputs are valid every cycle, compare one entry per edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                me = q.pop_front();
                checks++;
                if (bus.clken !== me.ck || bus.clk_sq !== me.sq || bus.rd_en_mask !== me.en ||
                    bus.rd_data !== me.rd || bus.ready !== me.rdy) begin
                    failures++;
                    if (shown < 20) begin
                        shown++;
                        $display("FAIL scoreboard t=%0t clken=%b exp %b clk_sq=%b exp %b en=%b exp %b rd=%h exp %h ready=%b exp %b",
                                 $time, bus.clken, me.ck, bus.clk_sq, me.sq, bus.rd_en_mask, me.en,
                                 bus.rd_data, me.rd, bus.ready, me.rdy);
                    end
                end
            end
        end
    end

    initial begin
        logic [W-1:0] d;
        int           r;
        int           ch;
        checks = 0; failures = 0; shown = 0; rd_ch = 0;
        bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_sel = 1'b0; bus.wr_data = '0; bus.sync = 1'b0;
        model_reset();

        // Reset state, then defaults: 512-cycle pulses, ready at 1024.
        repeat (3) cyc(1'b0, 0, 1'b0, '0, 1'b0);
        release_rst();
        idle(1100);

        // clk/2 on ch1, then saturation and out-of-range channel.
        wr(1, 1'b0, 24'h800000); idle(20);
        wr(0, 1'b0, 24'h900000); idle(5);
        wr(5, 1'b0, 24'h123456); idle(5);
        wr(5, 1'b1, 24'h000000); idle(5);
        wr(0, 1'b0, 24'h000003); idle(50);
        wr(0, 1'b0, 24'h000000); idle(20);

        // Different phases, then equal increments and sync -> coincident pulses.
        wr(0, 1'b0, 24'h01F3A1); wr(1, 1'b0, 24'h05E0C7); idle(137);
        wr(0, 1'b0, 24'h040000); wr(1, 1'b0, 24'h040000); idle(9);
        cyc(1'b0, 1, 1'b0, '0, 1'b1); idle(200);
        // sync and write in the same cycle.
        rd_ch = 0; cyc(1'b1, 0, 1'b0, 24'h0A0000, 1'b1); idle(100);

        // Disable ch1 for 100 cycles, then re-enable.
        wr(1, 1'b1, 24'h000000); idle(99);
        wr(1, 1'b1, 24'h000001); idle(300);

        // Randomized register traffic and sync pulses.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 31));
            if (r == 0) begin
                cyc(1'b0, rd_ch, 1'b0, '0, 1'b1);
            end else if (r < 4) begin
                ch = int'($urandom_range(0, 7));
                case ($urandom_range(0, 5))
                    0:       d = W'($urandom);
                    1:       d = W'($urandom_range(0, 1000));
                    2:       d = '0;
                    3:       d = W'(HALF);
                    4:       d = W'(HALF + 1);
                    default: d = W'($urandom) >> 1;
                endcase
                rd_ch = ch;
                cyc(1'b1, ch, ($urandom_range(0, 3) == 0), d, (r == 3));
            end else begin
                idle(1);
            end
        end

        // Reset mid-run: increments revert, ready must settle again.
        wr(1, 1'b0, 24'h7FFFFF); idle(10);
        async_rst();
        release_rst();
        idle(1100);

        @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
